// File: rtl/vme_bus_master.sv
// rtl/vme_bus_master.sv - VME-style register bus initiator with command/response streams and timeout
//
// Purpose:
//   Accepts one command at a time on a valid/ready stream and issues a
//   single-cycle VMERdMem/VMEWrMem strobe. It then waits for the matching
//   Done or Error pulse, or for the timeout. The result is returned on a
//   valid/ready response stream.
//
// Ports:
//   Clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_we, cmd_addr, cmd_wdata command fields (word address [19:2])
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err,
//   rsp_timeout                 response fields
//   err_cnt                     saturating count of error responses
//   VMEAddr, VMEWrData          bus address/data, held for the transaction
//   VMERdMem, VMEWrMem          one-cycle bus strobes
//   VMERdData                   bus read data, valid with VMERdDone
//   VMERdDone, VMEWrDone        completion pulses
//   VMERdError, VMEWrError      error pulses

module vme_bus_master #(
  parameter int G_TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [17:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [7:0]  err_cnt,
  output logic [17:0] VMEAddr,
  output logic [31:0] VMEWrData,
  output logic        VMERdMem,
  output logic        VMEWrMem,
  input  logic [31:0] VMERdData,
  input  logic        VMERdDone,
  input  logic        VMEWrDone,
  input  logic        VMERdError,
  input  logic        VMEWrError
);

  localparam logic [15:0] L_TIMEOUT = 16'(G_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Registered datapath and its next values
  logic [15:0] r_cnt,       w_cnt_nxt;
  logic        r_we,        w_we_nxt;
  logic [17:0] r_addr,      w_addr_nxt;
  logic [31:0] r_wdata,     w_wdata_nxt;
  logic        r_rdmem,     w_rdmem_nxt;
  logic        r_wrmem,     w_wrmem_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err,   w_rsp_err_nxt;
  logic        r_rsp_to,    w_rsp_to_nxt;
  logic [7:0]  r_err_cnt,   w_err_cnt_nxt;

  // Direction-filtered completion inputs: a read only listens to the read
  // pulses and a write only to the write pulses.
  logic        w_done;
  logic        w_err;
  // r_cnt == 0 marks the strobe cycle itself; answers are only sampled from
  // wait cycle 1 onward.
  logic        w_live;
  logic        w_last;
  logic        w_accept;

  assign w_done   = r_we ? VMEWrDone  : VMERdDone;
  assign w_err    = r_we ? VMEWrError : VMERdError;
  assign w_live   = (r_cnt != 16'd0);
  assign w_last   = (r_cnt == L_TIMEOUT);
  assign w_accept = cmd_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_state_nxt = S_WAIT;
      S_WAIT: if (w_live && (w_done || w_err || w_last)) w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rdmem_nxt     = 1'b0;
    w_wrmem_nxt     = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_to_nxt    = r_rsp_to;
    w_err_cnt_nxt   = r_err_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          w_we_nxt    = cmd_we;
          w_wrmem_nxt = cmd_we;
          w_rdmem_nxt = !cmd_we;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_WAIT: begin
        if (!w_live) begin
          w_cnt_nxt = 16'd1;
        end else if (w_err) begin
          // Error wins over a Done in the same cycle
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_to_nxt    = 1'b0;
          w_rsp_rdata_nxt = 32'd0;
          if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
        end else if (w_done) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_to_nxt    = 1'b0;
          w_rsp_rdata_nxt = r_we ? 32'd0 : VMERdData;
        end else if (w_last) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_to_nxt    = 1'b1;
          w_rsp_rdata_nxt = 32'd0;
          if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: begin
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 16'd0;
      r_we        <= 1'b0;
      r_addr      <= 18'd0;
      r_wdata     <= 32'd0;
      r_rdmem     <= 1'b0;
      r_wrmem     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdmem     <= w_rdmem_nxt;
      r_wrmem     <= w_wrmem_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_to    <= w_rsp_to_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_to;
  assign err_cnt     = r_err_cnt;
  assign VMEAddr     = r_addr;
  assign VMEWrData   = r_wdata;
  assign VMERdMem    = r_rdmem;
  assign VMEWrMem    = r_wrmem;

endmodule

// File: tb/tb_vme_bus_master.sv
// tb/tb_vme_bus_master.sv - table-driven bench for vme_bus_master
module tb_vme_bus_master;

  logic        Clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  err_cnt;
  logic [17:0] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic [31:0] VMERdData;
  logic        VMERdDone;
  logic        VMEWrDone;
  logic        VMERdError;
  logic        VMEWrError;

  vme_bus_master #(.G_TIMEOUT(64)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_cnt(err_cnt),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // kind: 0 no answer, 1 matching Done, 2 matching Error,
  //       3 matching Done+Error, 4 Done of the other direction
  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    int          kind;
    int          k;
    logic [31:0] rdin;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    logic [7:0]  exp_cnt;
    int          hold;
    logic        late;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_pulses();
    VMERdDone = 0; VMEWrDone = 0; VMERdError = 0; VMEWrError = 0;
    VMERdData = 32'hDEADDEAD;
  endtask

  // Issues one command and plays the responder; c counts cycles after the
  // handshake edge, so rsp_valid is expected at c == 2 + k.
  task automatic run_txn(input vec_t v);
    int seen, rd_strb, wr_strb, bad_hold;
    @(negedge Clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
    rsp_ready = 0;
    @(negedge Clk);
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
    seen = 0; rd_strb = 0; wr_strb = 0; bad_hold = 0;
    for (int c = 1; c <= 200 && seen == 0; c++) begin
      if (c > 1) @(negedge Clk);
      clear_pulses();
      if (rsp_valid === 1'b1) begin
        seen = c;
      end else begin
        rd_strb += int'(VMERdMem);
        wr_strb += int'(VMEWrMem);
        if (VMEAddr !== v.addr || VMEWrData !== v.wdata) bad_hold++;
        if (c == 1 + v.k) begin
          VMERdData = v.rdin;
          case (v.kind)
            1: if (v.we) VMEWrDone = 1; else VMERdDone = 1;
            2: if (v.we) VMEWrError = 1; else VMERdError = 1;
            3: if (v.we) begin VMEWrDone = 1; VMEWrError = 1; end
               else begin VMERdDone = 1; VMERdError = 1; end
            4: if (v.we) VMERdDone = 1; else VMEWrDone = 1;
            default: ;
          endcase
        end
      end
    end
    chk("latency", seen, v.exp_lat);
    chk("rd_strobes", rd_strb, v.we ? 0 : 1);
    chk("wr_strobes", wr_strb, v.we ? 1 : 0);
    chk("addr_data_held", bad_hold, 0);
    if (seen != 0) begin
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_err", rsp_err, v.exp_err);
      chk("rsp_timeout", rsp_timeout, v.exp_to);
      chk("err_cnt", err_cnt, v.exp_cnt);
      chk("cmd_ready_resp", cmd_ready, 0);
      for (int h = 0; h < v.hold; h++) begin
        if (v.late) begin
          VMERdDone = 1; VMEWrDone = 1; VMERdData = 32'hABCD0123;
        end
        @(negedge Clk);
        clear_pulses();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, v.exp_rdata);
        chk("hold_err", {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
        chk("hold_cnt", err_cnt, v.exp_cnt);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1;
      @(negedge Clk);
      rsp_ready = 0;
      chk("rsp_valid_cleared", rsp_valid, 0);
      chk("cmd_ready_after", cmd_ready, 1);
    end
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0;
    clear_pulses();

    //          we addr       wdata          kind k   rdin          exp_rdata     err to lat cnt hold late
    vecs[0] = '{0, 18'h00010, 32'h0,         1,   1,  32'h000000A5, 32'h000000A5, 0, 0, 3,  0,  0,   0};
    vecs[1] = '{1, 18'h00001, 32'h0000BEEF,  1,   2,  32'h0,        32'h0,        0, 0, 4,  0,  10,  0};
    vecs[2] = '{0, 18'h3FFFF, 32'h11,        3,   1,  32'h1234,     32'h0,        1, 0, 3,  1,  0,   0};
    vecs[3] = '{1, 18'h2AAAA, 32'hFFFFFFFF,  2,   5,  32'h0,        32'h0,        1, 0, 7,  2,  0,   0};
    vecs[4] = '{0, 18'h00002, 32'h0,         1,   64, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 66, 2,  0,   0};
    vecs[5] = '{0, 18'h00003, 32'h0,         4,   1,  32'h55,       32'h0,        1, 1, 66, 3,  0,   0};
    vecs[6] = '{1, 18'h00004, 32'h77,        4,   2,  32'h66,       32'h0,        1, 1, 66, 4,  0,   0};
    vecs[7] = '{0, 18'h00005, 32'h0,         0,   1,  32'h0,        32'h0,        1, 1, 66, 5,  3,   1};

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_outputs", {VMERdMem, VMEWrMem, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rst_addr", VMEAddr, 0);
    chk("rst_wdata", VMEWrData, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1;
    @(negedge Clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Late answers in IDLE never produce a response
    @(negedge Clk);
    VMERdDone = 1; VMEWrDone = 1; VMERdError = 1; VMEWrError = 1;
    @(negedge Clk);
    clear_pulses();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("idle_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
    end
    chk("idle_err_cnt", err_cnt, 5);

    // 300 bus errors saturate err_cnt
    for (int i = 0; i < 300; i++) begin
      v = '{0, 18'(i), 32'h0, 2, 1, 32'h0, 32'h0, 1, 0, 3,
            8'((6 + i > 255) ? 255 : 6 + i), 0, 0};
      run_txn(v);
    end
    chk("err_cnt_sat", err_cnt, 255);

    // Reset during the strobe cycle of a read
    @(negedge Clk);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 18'h00777;
    @(negedge Clk);
    cmd_valid = 0;
    chk("pre_rst_strobe", VMERdMem, 1);
    rst_n = 0;
    #1;
    chk("async_rst_strobe", VMERdMem, 0);
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_cnt", err_cnt, 0);
    chk("async_rst_addr", VMEAddr, 0);
    @(negedge Clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge Clk);
      chk("rst_no_rsp", rsp_valid, 0);
    end
    v = vecs[0];
    v.addr = 18'h00123; v.rdin = 32'h5A5A0001; v.exp_rdata = 32'h5A5A0001;
    run_txn(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
